// File: rtl/neuro_pkg.sv
// Shared widths, FSM state type and signed saturation helper for the LIF neuron update stage.
package neuro_pkg;

   localparam int DEF_CUR_W  = 16;
   localparam int DEF_VMEM_W = 16;
   localparam int DEF_REF_W  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } lif_state_e;

   // Clamp a signed value into the range of a w-bit signed number (w <= 31).
   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                     input int unsigned w);
      logic signed [31:0] max_v;
      logic signed [31:0] min_v;
      max_v = (32'sd1 <<< (w - 1)) - 32'sd1;
      min_v = -(32'sd1 <<< (w - 1));
      if (v > max_v)
         return max_v;
      else if (v < min_v)
         return min_v;
      else
         return v;
   endfunction

endpackage

// File: rtl/lif_lane.sv
// Combinational single-neuron leaky integrate-and-fire update.
// Leak is present only when LIF_LEAK_EN is defined; otherwise pure integrate-and-fire.
module lif_lane
   import neuro_pkg::*;
#(
   parameter int VMEM_W     = DEF_VMEM_W,
   parameter int CUR_W      = DEF_CUR_W,
   parameter int REF_W      = DEF_REF_W,
   parameter int LEAK_SHIFT = 4
) (
   input  logic signed [VMEM_W-1:0] vmem_i,
   input  logic        [REF_W-1:0]  refcnt_i,
   input  logic signed [CUR_W-1:0]  cur_i,
   input  logic signed [VMEM_W-1:0] vth_i,
   input  logic        [REF_W-1:0]  rpr_i,
   output logic signed [VMEM_W-1:0] vmem_next_o,
   output logic        [REF_W-1:0]  refcnt_next_o,
   output logic                     spike_o
);

   localparam int WW = VMEM_W + 2;

   if (LEAK_SHIFT < 0 || LEAK_SHIFT >= VMEM_W || CUR_W > VMEM_W + 1) begin : g_bad_cfg
      $error("lif_lane: unsupported LEAK_SHIFT/CUR_W for VMEM_W");
   end

   logic signed [WW-1:0] v_ext;
   logic signed [WW-1:0] leak;
   logic signed [WW-1:0] cur_ext;
   logic signed [WW-1:0] vth_ext;
   logic signed [WW-1:0] v_sum;

   always_comb begin
      v_ext   = WW'(vmem_i);
      cur_ext = WW'(cur_i);
      vth_ext = WW'(vth_i);
`ifdef LIF_LEAK_EN
      leak    = v_ext >>> LEAK_SHIFT;
`else
      leak    = '0;
`endif
      v_sum   = v_ext - leak + cur_ext;
   end

   always_comb begin
      vmem_next_o   = '0;
      refcnt_next_o = refcnt_i;
      spike_o       = 1'b0;
      if (refcnt_i != '0) begin
         refcnt_next_o = refcnt_i - REF_W'(1);
      end else if (v_sum >= vth_ext) begin
         spike_o       = 1'b1;
         refcnt_next_o = rpr_i;
      end else begin
         vmem_next_o   = VMEM_W'(sat_signed(32'(v_sum), VMEM_W));
      end
   end

endmodule

// File: rtl/lif_neuron_update.sv
// LIF update stage: integrates one current vector per timestep, LANES neurons per cycle,
// and returns a packed spike word. Optional leak enabled by macro LIF_LEAK_EN.
//
//   state  | meaning
//   IDLE   | ready for a current vector or a state clear
//   UPDATE | sweeping neuron groups, one group of LANES per cycle
//   DONE   | spike word presented, waiting for spk_ready
module lif_neuron_update
   import neuro_pkg::*;
#(
   parameter int NUM_NEURONS = 32,
   parameter int LANES       = 4,
   parameter int CUR_W       = DEF_CUR_W,
   parameter int VMEM_W      = DEF_VMEM_W,
   parameter int LEAK_SHIFT  = 4,
   parameter int REF_W       = DEF_REF_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cur_valid,
   output logic                         cur_ready,
   input  logic [NUM_NEURONS*CUR_W-1:0] cur_vec,
   input  logic [31:0]                  vtr,
   input  logic [31:0]                  rpr,
   input  logic                         clr_state,
   output logic                         spk_valid,
   input  logic                         spk_ready,
   output logic [NUM_NEURONS-1:0]       spk_word,
   output logic                         busy,
   output logic [31:0]                  spike_count
);

   localparam int NGRP   = NUM_NEURONS / LANES;
   localparam int LIDX_W = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam int NIDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int POP_W  = $clog2(LANES + 1);

   if (NUM_NEURONS % LANES != 0) begin : g_bad_lanes
      $error("lif_neuron_update: NUM_NEURONS must be a multiple of LANES");
   end

   lif_state_e                   state_q, state_d;
   logic [LIDX_W-1:0]            lane_q, lane_d;
   logic signed [VMEM_W-1:0]     vmem_q [NUM_NEURONS];
   logic [REF_W-1:0]             ref_q  [NUM_NEURONS];
   logic [NUM_NEURONS*CUR_W-1:0] cur_buf_q;
   logic signed [VMEM_W-1:0]     vth_q;
   logic [REF_W-1:0]             rpr_q;
   logic [NUM_NEURONS-1:0]       spk_q;
   logic [31:0]                  cnt_q, cnt_d;

   logic                         accept;
   logic                         clr;
   logic [NIDX_W-1:0]            nidx      [LANES];
   logic signed [VMEM_W-1:0]     lane_vmem [LANES];
   logic [REF_W-1:0]             lane_ref  [LANES];
   logic [LANES-1:0]             lane_spk;
   logic [POP_W-1:0]             pop;
   logic [32:0]                  cnt_sum;
   logic                         unused_cfg;

   assign unused_cfg = ^{vtr[31:VMEM_W], rpr[31:REF_W]};

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign nidx[l] = NIDX_W'(lane_q * LANES + l);

      lif_lane #(
         .VMEM_W     (VMEM_W),
         .CUR_W      (CUR_W),
         .REF_W      (REF_W),
         .LEAK_SHIFT (LEAK_SHIFT)
      ) u_lane (
         .vmem_i        (vmem_q[nidx[l]]),
         .refcnt_i      (ref_q[nidx[l]]),
         .cur_i         (cur_buf_q[nidx[l]*CUR_W +: CUR_W]),
         .vth_i         (vth_q),
         .rpr_i         (rpr_q),
         .vmem_next_o   (lane_vmem[l]),
         .refcnt_next_o (lane_ref[l]),
         .spike_o       (lane_spk[l])
      );
   end

   always_comb begin
      pop = '0;
      for (int l = 0; l < LANES; l++)
         pop = pop + POP_W'(lane_spk[l]);
      cnt_sum = {1'b0, cnt_q} + 33'(pop);
      cnt_d   = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
   end

   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      accept    = 1'b0;
      clr       = 1'b0;
      cur_ready = 1'b0;
      spk_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy      = 1'b0;
            cur_ready = ~clr_state;
            if (clr_state) begin
               clr = 1'b1;
            end else if (cur_valid) begin
               accept  = 1'b1;
               lane_d  = '0;
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            lane_d = lane_q + LIDX_W'(1);
            if (lane_q == LIDX_W'(NGRP - 1))
               state_d = DONE;
         end
         DONE: begin
            spk_valid = 1'b1;
            if (spk_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         lane_q    <= '0;
         cur_buf_q <= '0;
         vth_q     <= '0;
         rpr_q     <= '0;
         spk_q     <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            vmem_q[i] <= '0;
            ref_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         if (clr) begin
            cnt_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
               vmem_q[i] <= '0;
               ref_q[i]  <= '0;
            end
         end
         // Thresholds are latched so later vtr/rpr changes leave this timestep alone.
         if (accept) begin
            cur_buf_q <= cur_vec;
            vth_q     <= vtr[VMEM_W-1:0];
            rpr_q     <= rpr[REF_W-1:0];
            spk_q     <= '0;
         end
         if (state_q == UPDATE) begin
            cnt_q <= cnt_d;
            for (int l = 0; l < LANES; l++) begin
               vmem_q[nidx[l]] <= lane_vmem[l];
               ref_q[nidx[l]]  <= lane_ref[l];
               spk_q[nidx[l]]  <= lane_spk[l];
            end
         end
      end
   end

   assign spk_word    = spk_q;
   assign spike_count = cnt_q;

endmodule
